// File: rtl/regfile_check_harness.sv
// regfile_check_harness
//   Register-file self-check engine placed between a processor and its
//   register file. A run lets the processor execute for a programmed number
//   of cycles while register writes are snooped into a trace FIFO. Read port
//   A is then taken over to scan every register, and each value is compared
//   with an expected-value memory. Mismatches are reported one at a time,
//   and an error count plus pass/done flags summarise the scan.
//
// Optional feature macro: REGFILE_CHECK_TRACE_EN
//   defined     : trace FIFO present, trace_* ports active
//   not defined : no FIFO storage, trace outputs tied 0, i_trace_ready ignored
//
// Ports
//   i_clock, i_reset_n              clock, asynchronous active-low reset
//   i_start, i_num_cycles           run request pulse and run length
//   i_proc_rwe/rd/wdata             snooped processor register write
//   i_proc_rs1 -> o_rf_rs1          read-A index, replaced by scan index in SCAN
//   i_rf_dataA                      register file read-A data (combinational)
//   o_exp_addr, i_exp_data          expected memory, one-cycle read latency
//   o_busy, o_done, o_pass          status (busy = RUN or SCAN)
//   o_err_count                     mismatches seen in the last scan
//   o_fail_valid/reg/exp/act        per-mismatch report (holds last failure)
//   o_trace_valid, i_trace_ready    trace FIFO head handshake
//   o_trace_cycle/reg/data          trace FIFO head entry
//   o_trace_ovf                     sticky: a snooped write was dropped
module regfile_check_harness #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 5,
  parameter int NUM_REGS    = 32,
  parameter int CYC_W       = 16,
  parameter int TRACE_DEPTH = 8
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic              i_start,
  input  logic [CYC_W-1:0]  i_num_cycles,
  input  logic              i_proc_rwe,
  input  logic [ADDR_W-1:0] i_proc_rd,
  input  logic [DATA_W-1:0] i_proc_wdata,
  input  logic [ADDR_W-1:0] i_proc_rs1,
  output logic [ADDR_W-1:0] o_rf_rs1,
  input  logic [DATA_W-1:0] i_rf_dataA,
  output logic [ADDR_W-1:0] o_exp_addr,
  input  logic [DATA_W-1:0] i_exp_data,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_pass,
  output logic [ADDR_W:0]   o_err_count,
  output logic              o_fail_valid,
  output logic [ADDR_W-1:0] o_fail_reg,
  output logic [DATA_W-1:0] o_fail_exp,
  output logic [DATA_W-1:0] o_fail_act,
  output logic              o_trace_valid,
  input  logic              i_trace_ready,
  output logic [CYC_W-1:0]  o_trace_cycle,
  output logic [ADDR_W-1:0] o_trace_reg,
  output logic [DATA_W-1:0] o_trace_data,
  output logic              o_trace_ovf
);

  localparam int IDX_W = ADDR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_SCAN, S_DONE} state_t;

  state_t            r_state;
  logic [CYC_W-1:0]  r_cycle_cnt;
  logic [CYC_W-1:0]  r_num_cycles;
  logic [IDX_W-1:0]  r_scan_idx;
  logic              r_busy;
  logic              r_done;
  logic [ADDR_W:0]   r_err_count;
  logic              r_fail_valid;
  logic [ADDR_W-1:0] r_fail_reg;
  logic [DATA_W-1:0] r_fail_exp;
  logic [DATA_W-1:0] r_fail_act;
  logic              r_cmp_vld_p1;
  logic [ADDR_W-1:0] r_cmp_reg_p1;
  logic [DATA_W-1:0] r_act_p1;

  logic w_start_acc;
  logic w_run_last;
  logic w_scan_last;
  logic w_mismatch;

  // Error counter saturates rather than wrapping.
  function automatic logic [ADDR_W:0] sat_inc(input logic [ADDR_W:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  assign w_start_acc = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));
  // A zero-length run still spends one cycle in RUN.
  assign w_run_last  = (r_num_cycles == '0) || (r_cycle_cnt == r_num_cycles - CYC_W'(1));
  // Final SCAN cycle issues no read; it only completes the last compare.
  assign w_scan_last = (r_scan_idx == IDX_W'(NUM_REGS));
  assign w_mismatch  = r_cmp_vld_p1 && (r_act_p1 !== i_exp_data);

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state      <= S_IDLE;
      r_cycle_cnt  <= '0;
      r_num_cycles <= '0;
      r_scan_idx   <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err_count  <= '0;
      r_fail_valid <= 1'b0;
      r_fail_reg   <= '0;
      r_fail_exp   <= '0;
      r_fail_act   <= '0;
      r_cmp_vld_p1 <= 1'b0;
      r_cmp_reg_p1 <= '0;
    end else begin
      r_fail_valid <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_start_acc) begin
            r_state      <= S_RUN;
            r_cycle_cnt  <= '0;
            r_num_cycles <= i_num_cycles;
            r_scan_idx   <= '0;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_err_count  <= '0;
          end
        end
        S_RUN: begin
          r_cycle_cnt <= r_cycle_cnt + 1'b1;
          if (w_run_last) begin
            r_state    <= S_SCAN;
            r_scan_idx <= '0;
          end
        end
        S_SCAN: begin
          if (w_scan_last) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_scan_idx <= r_scan_idx + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // p0 -> p1: read issued this cycle, compared next cycle.
      r_cmp_vld_p1 <= (r_state == S_SCAN) && !w_scan_last;
      r_cmp_reg_p1 <= r_scan_idx[ADDR_W-1:0];

      // p1: compare against expected memory output.
      if (w_mismatch) begin
        r_fail_valid <= 1'b1;
        r_fail_reg   <= r_cmp_reg_p1;
        r_fail_exp   <= i_exp_data;
        r_fail_act   <= r_act_p1;
        r_err_count  <= sat_inc(r_err_count);
      end
    end
  end

  always_ff @(posedge i_clock) begin
    r_act_p1 <= i_rf_dataA;
  end

  assign o_rf_rs1     = (r_state == S_SCAN) ? r_scan_idx[ADDR_W-1:0] : i_proc_rs1;
  assign o_exp_addr   = r_scan_idx[ADDR_W-1:0];
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_pass       = r_done && (r_err_count == '0);
  assign o_err_count  = r_err_count;
  assign o_fail_valid = r_fail_valid;
  assign o_fail_reg   = r_fail_reg;
  assign o_fail_exp   = r_fail_exp;
  assign o_fail_act   = r_fail_act;

`ifdef REGFILE_CHECK_TRACE_EN
  localparam int PTR_W = $clog2(TRACE_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_ovf;
  logic [CYC_W-1:0]  r_mem_cycle [TRACE_DEPTH];
  logic [ADDR_W-1:0] r_mem_reg   [TRACE_DEPTH];
  logic [DATA_W-1:0] r_mem_data  [TRACE_DEPTH];

  logic w_push_req;
  logic w_push;
  logic w_pop;
  logic w_full;

  assign w_pop      = (r_count != '0) && i_trace_ready;
  assign w_full     = (r_count == CNT_W'(TRACE_DEPTH));
  assign w_push_req = (r_state == S_RUN) && i_proc_rwe && (i_proc_rd != '0);
  // When full, a same-cycle pop frees the slot the push needs.
  assign w_push     = w_push_req && (!w_full || w_pop);

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else if (w_start_acc) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_push_req && !w_push) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge i_clock) begin
    if (w_push) begin
      r_mem_cycle[r_wr_ptr] <= r_cycle_cnt;
      r_mem_reg[r_wr_ptr]   <= i_proc_rd;
      r_mem_data[r_wr_ptr]  <= i_proc_wdata;
    end
  end

  assign o_trace_valid = (r_count != '0);
  assign o_trace_cycle = r_mem_cycle[r_rd_ptr];
  assign o_trace_reg   = r_mem_reg[r_rd_ptr];
  assign o_trace_data  = r_mem_data[r_rd_ptr];
  assign o_trace_ovf   = r_ovf;
`else
  // Snoop inputs have no consumer without the trace FIFO.
  logic w_unused_snoop;
  assign w_unused_snoop = ^{i_trace_ready, i_proc_rwe, i_proc_rd, i_proc_wdata};

  assign o_trace_valid = 1'b0;
  assign o_trace_cycle = '0;
  assign o_trace_reg   = '0;
  assign o_trace_data  = '0;
  assign o_trace_ovf   = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_check_harness.sv
module tb_regfile_check_harness;
  localparam int DATA_W      = 32;
  localparam int ADDR_W      = 5;
  localparam int NUM_REGS    = 32;
  localparam int CYC_W       = 16;
  localparam int TRACE_DEPTH = 8;

  logic              clk;
  logic              reset_n;
  logic              start;
  logic [CYC_W-1:0]  num_cycles;
  logic              proc_rwe;
  logic [ADDR_W-1:0] proc_rd;
  logic [DATA_W-1:0] proc_wdata;
  logic [ADDR_W-1:0] proc_rs1;
  logic [ADDR_W-1:0] rf_rs1;
  logic [DATA_W-1:0] rf_dataA;
  logic [ADDR_W-1:0] exp_addr;
  logic [DATA_W-1:0] exp_data;
  logic              busy, done, pass;
  logic [ADDR_W:0]   err_count;
  logic              fail_valid;
  logic [ADDR_W-1:0] fail_reg;
  logic [DATA_W-1:0] fail_exp, fail_act;
  logic              trace_valid, trace_ready;
  logic [CYC_W-1:0]  trace_cycle;
  logic [ADDR_W-1:0] trace_reg;
  logic [DATA_W-1:0] trace_data;
  logic              trace_ovf;

  regfile_check_harness #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS),
    .CYC_W(CYC_W), .TRACE_DEPTH(TRACE_DEPTH)
  ) dut (
    .i_clock(clk), .i_reset_n(reset_n), .i_start(start), .i_num_cycles(num_cycles),
    .i_proc_rwe(proc_rwe), .i_proc_rd(proc_rd), .i_proc_wdata(proc_wdata),
    .i_proc_rs1(proc_rs1), .o_rf_rs1(rf_rs1), .i_rf_dataA(rf_dataA),
    .o_exp_addr(exp_addr), .i_exp_data(exp_data),
    .o_busy(busy), .o_done(done), .o_pass(pass), .o_err_count(err_count),
    .o_fail_valid(fail_valid), .o_fail_reg(fail_reg), .o_fail_exp(fail_exp),
    .o_fail_act(fail_act), .o_trace_valid(trace_valid), .i_trace_ready(trace_ready),
    .o_trace_cycle(trace_cycle), .o_trace_reg(trace_reg), .o_trace_data(trace_data),
    .o_trace_ovf(trace_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file (combinational read) and expected memory (registered read).
  logic [DATA_W-1:0] rf   [NUM_REGS];
  logic [DATA_W-1:0] expm [NUM_REGS];
  assign rf_dataA = rf[rf_rs1];
  always @(posedge clk) exp_data <= expm[exp_addr];

  typedef struct {
    logic [ADDR_W-1:0] r;
    logic [DATA_W-1:0] e;
    logic [DATA_W-1:0] a;
  } fail_t;
  typedef struct {
    logic [CYC_W-1:0]  c;
    logic [ADDR_W-1:0] r;
    logic [DATA_W-1:0] d;
  } tr_t;

  fail_t fq[$];
  tr_t   tq[$];

  logic              wr_en  [64];
  logic [ADDR_W-1:0] wr_rd  [64];
  logic [DATA_W-1:0] wr_dat [64];
  logic              rdy    [64];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_match();
    for (int i = 0; i < NUM_REGS; i++) begin
      rf[i]   = $urandom;
      expm[i] = rf[i];
    end
  endtask

  // Scoreboard: one expected failure report per differing register, in scan order.
  task automatic build_fq();
    fail_t f;
    fq.delete();
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rf[i] !== expm[i]) begin
        f.r = ADDR_W'(i);
        f.e = expm[i];
        f.a = rf[i];
        fq.push_back(f);
      end
    end
  endtask

  task automatic clear_wr();
    for (int i = 0; i < 64; i++) begin
      wr_en[i] = 1'b0; wr_rd[i] = '0; wr_dat[i] = '0; rdy[i] = 1'b0;
    end
  endtask

  // Called at a falling edge with the DUT idle or done.
  task automatic run_scan(input logic [CYC_W-1:0] ncyc, input int restart_at,
                          input int exp_busy, input int exp_err, input string tag);
    fail_t f;
    int    busy_cnt;
    bit    got_done;
    busy_cnt = 0;
    got_done = 1'b0;
    start = 1'b1;
    num_cycles = ncyc;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      start = (i == restart_at);
      if (i == restart_at) num_cycles = 16'd10;
      if (fail_valid) begin
        if (fq.size() == 0) begin
          check({tag, " unexpected fail_valid"}, 64'(fail_reg), 64'hFFFF);
        end else begin
          f = fq.pop_front();
          check({tag, " fail_reg"}, 64'(fail_reg), 64'(f.r));
          check({tag, " fail_exp"}, 64'(fail_exp), 64'(f.e));
          check({tag, " fail_act"}, 64'(fail_act), 64'(f.a));
        end
      end
      if (busy) busy_cnt++;
      if (done) begin
        got_done = 1'b1;
        break;
      end
    end
    start = 1'b0;
    check({tag, " done reached"}, 64'(got_done), 64'd1);
    check({tag, " busy cycles"}, 64'(busy_cnt), 64'(exp_busy));
    check({tag, " missing fail reports"}, 64'(fq.size()), 64'd0);
    check({tag, " err_count"}, 64'(err_count), 64'(exp_err));
    check({tag, " pass"}, 64'(pass), 64'(exp_err == 0));
  endtask

  // Run with snooped writes taken from wr_* and consumer readiness from rdy.
  task automatic run_trace(input logic [CYC_W-1:0] ncyc, input string tag);
    tr_t t;
    bit  got_done;
    tq.delete();
    got_done = 1'b0;
    start = 1'b1;
    num_cycles = ncyc;
    for (int c = 0; c < int'(ncyc); c++) begin
      @(negedge clk);
      start = 1'b0;
`ifdef REGFILE_CHECK_TRACE_EN
      check({tag, " trace_valid"}, 64'(trace_valid), 64'(tq.size() != 0));
      if (rdy[c] && tq.size() > 0) begin
        t = tq.pop_front();
        check({tag, " run pop cycle"}, 64'(trace_cycle), 64'(t.c));
        check({tag, " run pop reg"},   64'(trace_reg),   64'(t.r));
        check({tag, " run pop data"},  64'(trace_data),  64'(t.d));
      end
`else
      check({tag, " trace_valid tied"}, 64'(trace_valid), 64'd0);
`endif
      trace_ready = rdy[c];
      proc_rwe    = wr_en[c];
      proc_rd     = wr_rd[c];
      proc_wdata  = wr_dat[c];
      if (wr_en[c] && wr_rd[c] != '0 && tq.size() < TRACE_DEPTH) begin
        t.c = CYC_W'(c);
        t.r = wr_rd[c];
        t.d = wr_dat[c];
        tq.push_back(t);
      end
    end
    @(negedge clk);
    proc_rwe = 1'b0;
    trace_ready = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (done) begin
        got_done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({tag, " done reached"}, 64'(got_done), 64'd1);
  endtask

`ifdef REGFILE_CHECK_TRACE_EN
  task automatic drain(input int exp_entries, input string tag);
    tr_t t;
    int  n;
    n = 0;
    trace_ready = 1'b1;
    for (int g = 0; g < 20 && tq.size() > 0; g++) begin
      check({tag, " drain valid"}, 64'(trace_valid), 64'd1);
      t = tq.pop_front();
      check({tag, " drain cycle"}, 64'(trace_cycle), 64'(t.c));
      check({tag, " drain reg"},   64'(trace_reg),   64'(t.r));
      check({tag, " drain data"},  64'(trace_data),  64'(t.d));
      n++;
      @(negedge clk);
    end
    trace_ready = 1'b0;
    check({tag, " entries"}, 64'(n), 64'(exp_entries));
    check({tag, " empty after drain"}, 64'(trace_valid), 64'd0);
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; start = 1'b0; num_cycles = '0;
    proc_rwe = 1'b0; proc_rd = '0; proc_wdata = '0; proc_rs1 = 5'd7;
    trace_ready = 1'b0;
    clear_wr();
    fill_match();
    repeat (2) @(negedge clk);

    // Reset state.
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst pass", 64'(pass), 64'd0);
    check("rst fail_valid", 64'(fail_valid), 64'd0);
    check("rst err_count", 64'(err_count), 64'd0);
    check("rst fail_reg", 64'(fail_reg), 64'd0);
    check("rst fail_exp", 64'(fail_exp), 64'd0);
    check("rst fail_act", 64'(fail_act), 64'd0);
    check("rst trace_valid", 64'(trace_valid), 64'd0);
    check("rst trace_ovf", 64'(trace_ovf), 64'd0);
    check("rst rf_rs1 passthrough", 64'(rf_rs1), 64'd7);
    reset_n = 1'b1;
    @(negedge clk);
    check("idle busy", 64'(busy), 64'd0);

    // Clean run: 5 RUN + 33 SCAN cycles.
    fill_match();
    build_fq();
    run_scan(16'd5, -1, 38, 0, "clean");
    proc_rs1 = 5'd12;
    @(negedge clk);
    check("done holds", 64'(done), 64'd1);
    check("done rf_rs1 passthrough", 64'(rf_rs1), 64'd12);

    // Two mismatching registers.
    fill_match();
    rf[3] = 32'd7;           expm[3] = 32'd8;
    rf[31] = 32'hFFFF_FFFF;  expm[31] = 32'd0;
    build_fq();
    run_scan(16'd5, -1, 38, 2, "mismatch");
    @(negedge clk);
    check("fail pulse ends", 64'(fail_valid), 64'd0);
    check("fail_reg holds", 64'(fail_reg), 64'd31);
    check("fail_act holds", 64'(fail_act), 64'hFFFF_FFFF);

    // Zero-length run with a start pulse while busy.
    fill_match();
    build_fq();
    run_scan(16'd0, 0, 34, 0, "zero run");

    // Trace: r0 never traced, r4 write at run cycle 2.
    clear_wr();
    fill_match();
    build_fq();
    wr_en[1] = 1'b1; wr_rd[1] = 5'd0; wr_dat[1] = 32'd9;
    wr_en[2] = 1'b1; wr_rd[2] = 5'd4; wr_dat[2] = 32'h55;
    run_trace(16'd4, "trace r0");
`ifdef REGFILE_CHECK_TRACE_EN
    check("trace r0 head valid", 64'(trace_valid), 64'd1);
    check("trace r0 head cycle", 64'(trace_cycle), 64'd2);
    check("trace r0 head reg", 64'(trace_reg), 64'd4);
    check("trace r0 head data", 64'(trace_data), 64'h55);
    check("trace r0 ovf", 64'(trace_ovf), 64'd0);
    drain(1, "trace r0");
`else
    check("trace tied ovf", 64'(trace_ovf), 64'd0);
    check("trace tied cycle", 64'(trace_cycle), 64'd0);
    check("trace tied reg", 64'(trace_reg), 64'd0);
    check("trace tied data", 64'(trace_data), 64'd0);
`endif

    // Trace overflow: 10 writes, nothing consumed.
    clear_wr();
    for (int c = 0; c < 10; c++) begin
      wr_en[c] = 1'b1; wr_rd[c] = ADDR_W'(c + 1); wr_dat[c] = $urandom;
    end
    run_trace(16'd10, "trace ovf");
`ifdef REGFILE_CHECK_TRACE_EN
    check("trace ovf sticky", 64'(trace_ovf), 64'd1);
    drain(8, "trace ovf");
`else
    check("trace tied ovf2", 64'(trace_ovf), 64'd0);
`endif

    // Full FIFO, 9th write arrives together with a pop: no drop.
    clear_wr();
    for (int c = 0; c < 9; c++) begin
      wr_en[c] = 1'b1; wr_rd[c] = ADDR_W'(c + 10); wr_dat[c] = $urandom;
    end
    rdy[8] = 1'b1;
    run_trace(16'd9, "trace full pop");
`ifdef REGFILE_CHECK_TRACE_EN
    check("trace full pop ovf", 64'(trace_ovf), 64'd0);
    drain(8, "trace full pop");
`else
    check("trace tied valid", 64'(trace_valid), 64'd0);
`endif

    // Reset asserted mid-SCAN with one failure already counted.
    fill_match();
    rf[3] = 32'd7; expm[3] = 32'd8;
    fq.delete();
    proc_rs1 = 5'd20;
    start = 1'b1; num_cycles = 16'd2;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    check("midscan busy before", 64'(busy), 64'd1);
    check("midscan err before", 64'(err_count), 64'd1);
    reset_n = 1'b0;
    #1;
    check("midscan rst busy", 64'(busy), 64'd0);
    check("midscan rst done", 64'(done), 64'd0);
    check("midscan rst err", 64'(err_count), 64'd0);
    check("midscan rst rf_rs1", 64'(rf_rs1), 64'd20);
    check("midscan rst fail_reg", 64'(fail_reg), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("after reset idle", 64'(busy), 64'd0);
    check("after reset pass", 64'(pass), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
